// File: rtl/mul_pkg.sv
// Shared types and parameter limits for the pipelined integer multiplier.
package mul_pkg;

    typedef enum logic {
        MUL_UNSIGNED = 1'b0,
        MUL_SIGNED   = 1'b1
    } mul_mode_e;

    localparam int unsigned MIN_WIDTH  = 4;
    localparam int unsigned MIN_STAGES = 2;

endpackage

// File: rtl/mul_pipe_slot.sv
// One pipeline slot: valid bit plus data, loaded together when enabled.
module mul_pipe_slot #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          d_valid,
    input  logic [DW-1:0] d_data,
    output logic          q_valid,
    output logic [DW-1:0] q_data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready handshakes and a
// single global advance enable shared by every slot.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned STAGES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam int unsigned HW  = WIDTH / 2;
    localparam int unsigned EW  = WIDTH + 1;
    localparam int unsigned PPW = WIDTH + HW + 2;
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned SW  = PW + 2;

    if (WIDTH < MIN_WIDTH || (WIDTH % 2) != 0) begin : g_bad_width
        $error("mul_pipe: WIDTH must be even and at least MIN_WIDTH");
    end
    if (STAGES < MIN_STAGES) begin : g_bad_stages
        $error("mul_pipe: STAGES must be at least MIN_STAGES");
    end

    logic              adv;
    logic [STAGES-1:0] v;
    mul_mode_e         mode;
    logic [EW-1:0]     a_ext;
    logic [EW-1:0]     b_ext;
    logic [2*EW-1:0]   s0_q;

    assign adv       = !v[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v[STAGES-1];

    // Operand extension to WIDTH+1 bits makes both modes a signed multiply.
    always_comb begin
        mode  = mul_mode_e'(in_signed);
        a_ext = {(mode == MUL_SIGNED) & in_a[WIDTH-1], in_a};
        b_ext = {(mode == MUL_SIGNED) & in_b[WIDTH-1], in_b};
    end

    mul_pipe_slot #(.DW(2*EW)) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .en      (adv),
        .d_valid (in_valid),
        .d_data  ({b_ext, a_ext}),
        .q_valid (v[0]),
        .q_data  (s0_q)
    );

    // Split b into an unsigned low half and a signed upper part.
    logic signed [EW-1:0]  a_s;
    logic signed [HW:0]    bl_s;
    logic signed [HW:0]    bh_s;
    logic signed [PPW-1:0] pp_lo;
    logic signed [PPW-1:0] pp_hi;

    always_comb begin
        a_s   = s0_q[EW-1:0];
        bl_s  = {1'b0, s0_q[EW +: HW]};
        bh_s  = s0_q[2*EW-1 -: HW+1];
        pp_lo = PPW'(a_s) * PPW'(bl_s);
        pp_hi = PPW'(a_s) * PPW'(bh_s);
    end

    function automatic logic [PW-1:0] sum_pp(input logic signed [PPW-1:0] lo,
                                             input logic signed [PPW-1:0] hi);
        logic signed [SW-1:0] s;
        s = SW'(lo) + (SW'(hi) <<< HW);
        return s[PW-1:0];
    endfunction

    if (STAGES == 2) begin : g_merged
        mul_pipe_slot #(.DW(PW)) u_slot1 (
            .clk     (clk),
            .rst     (rst),
            .en      (adv),
            .d_valid (v[0]),
            .d_data  (sum_pp(pp_lo, pp_hi)),
            .q_valid (v[1]),
            .q_data  (out_p)
        );
    end else begin : g_split
        logic [2*PPW-1:0] s1_q;
        logic [PW-1:0]    pd [STAGES-1:2];

        mul_pipe_slot #(.DW(2*PPW)) u_slot1 (
            .clk     (clk),
            .rst     (rst),
            .en      (adv),
            .d_valid (v[0]),
            .d_data  ({pp_hi, pp_lo}),
            .q_valid (v[1]),
            .q_data  (s1_q)
        );

        for (genvar k = 2; k < STAGES; k++) begin : g_slot
            if (k == 2) begin : g_sum
                mul_pipe_slot #(.DW(PW)) u_slot (
                    .clk     (clk),
                    .rst     (rst),
                    .en      (adv),
                    .d_valid (v[1]),
                    .d_data  (sum_pp(s1_q[PPW-1:0], s1_q[2*PPW-1:PPW])),
                    .q_valid (v[2]),
                    .q_data  (pd[2])
                );
            end else begin : g_delay
                mul_pipe_slot #(.DW(PW)) u_slot (
                    .clk     (clk),
                    .rst     (rst),
                    .en      (adv),
                    .d_valid (v[k-1]),
                    .d_data  (pd[k-1]),
                    .q_valid (v[k]),
                    .q_data  (pd[k])
                );
            end
        end

        assign out_p = pd[STAGES-1];
    end

endmodule
